vote_capture: RTL and testbench

VOTE_CAPTURE -- requirements
Module: vote_capture

---
 rtl/vote_capture.sv | 85 ++++++++
 tb/tb_vote_capture.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vote_capture.sv
// vote_capture: synchronizes and debounces four candidate buttons and turns each clean,
// single-button press into a one-cycle vote pulse. Simultaneous presses are rejected.
module vote_capture #(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic mode,
    input  logic cand1_button,
    input  logic cand2_button,
    input  logic cand3_button,
    input  logic cand4_button,
    output logic cand1_vote_valid,
    output logic cand2_vote_valid,
    output logic cand3_vote_valid,
    output logic cand4_vote_valid,
    output logic invalid_press,
    output logic busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {IDLE, WAIT_RELEASE} state_t;

    logic [3:0]         btn, sync1_q, sync2_q, deb_q, deb_d, prev_q, vote_q, vote_d, rise;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic               invalid_q, invalid_d;
    state_t             state_q, state_d;

    assign btn = {cand4_button, cand3_button, cand2_button, cand1_button};

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) deb_d[i] = ~deb_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Votes trigger on a debounced rising edge, so a level held across a mode change never votes.
    assign rise = deb_q & ~prev_q;

    always_comb begin
        state_d   = state_q;
        vote_d    = '0;
        invalid_d = 1'b0;
        if (state_q == IDLE) begin
            if (!mode && |rise) begin
                state_d   = WAIT_RELEASE;
                invalid_d = $countones(deb_q) > 1;
                vote_d    = ($countones(deb_q) > 1) ? 4'b0000 : deb_q;
            end
        end else if (deb_q == 4'b0000) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            vote_q    <= '0;
            invalid_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            prev_q    <= deb_q;
            cnt_q     <= cnt_d;
            vote_q    <= vote_d;
            invalid_q <= invalid_d;
            state_q   <= state_d;
        end
    end

    assign {cand4_vote_valid, cand3_vote_valid, cand2_vote_valid, cand1_vote_valid} = vote_q;
    assign invalid_press = invalid_q;
    assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_vote_capture.sv
// tb_vote_capture: directed checks of vote_capture with DEBOUNCE_CYCLES=4.
module tb_vote_capture;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode  = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic       v1, v2, v3, v4, inv, busy;
    logic [4:0] pulses;
    int         total = 0;
    int         bad   = 0;

    assign pulses = {inv, v4, v3, v2, v1};

    always #5 clock = ~clock;

    vote_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .cand1_button(btn[0]), .cand2_button(btn[1]), .cand3_button(btn[2]), .cand4_button(btn[3]),
        .cand1_vote_valid(v1), .cand2_vote_valid(v2), .cand3_vote_valid(v3), .cand4_vote_valid(v4),
        .invalid_press(inv), .busy(busy)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        btn = 4'b1111;
        #1;
        total++; if (pulses !== 5'b0) begin bad++; $display("FAIL reset_pulses got=%b want=00000", pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        repeat (3) tick;
        total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_hold pulses=%b busy=%b want 00000/0", pulses, busy); end
        btn = 4'b0000;
        reset = 1'b1;
        repeat (10) begin
            tick;
            total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle pulses=%b busy=%b", pulses, busy); end
        end
    endtask

    task automatic test_press;
        btn = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            tick;
            total++; if (pulses !== ((k == 8) ? 5'b00010 : 5'b0)) begin bad++; $display("FAIL press k=%0d pulses=%b want=%b", k, pulses, (k == 8) ? 5'b00010 : 5'b0); end
            total++; if (busy !== (k >= 8)) begin bad++; $display("FAIL press_busy k=%0d got=%b want=%b", k, busy, k >= 8); end
        end
        btn = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++; if (pulses !== 5'b0) begin bad++; $display("FAIL release k=%0d pulses=%b want=00000", k, pulses); end
            total++; if (busy !== (k < 8)) begin bad++; $display("FAIL release_busy k=%0d got=%b want=%b", k, busy, k < 8); end
        end
    endtask

    task automatic test_glitch;
        btn = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            tick;
            if (k == 3) btn = 4'b0000;
            total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL glitch k=%0d pulses=%b busy=%b want 00000/0", k, pulses, busy); end
        end
    endtask

    task automatic test_multi;
        btn = 4'b1100;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++; if (pulses !== ((k == 8) ? 5'b10000 : 5'b0)) begin bad++; $display("FAIL multi k=%0d pulses=%b want=%b", k, pulses, (k == 8) ? 5'b10000 : 5'b0); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL multi_busy_held got=%b want=1", busy); end
        btn = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick;
            total++; if (pulses !== 5'b0 || busy !== (k < 8)) begin bad++; $display("FAIL multi_release k=%0d pulses=%b busy=%b want busy=%b", k, pulses, busy, k < 8); end
        end
    endtask

    task automatic test_mode;
        mode = 1'b1;
        btn  = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick;
            total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL mode1 k=%0d pulses=%b busy=%b", k, pulses, busy); end
        end
        mode = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL mode_held k=%0d pulses=%b busy=%b", k, pulses, busy); end
        end
        btn = 4'b0000;
        repeat (10) tick;
        total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL mode_release pulses=%b busy=%b", pulses, busy); end
        btn = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick;
            total++; if (pulses !== ((k == 8) ? 5'b00001 : 5'b0)) begin bad++; $display("FAIL mode_repress k=%0d pulses=%b want=%b", k, pulses, (k == 8) ? 5'b00001 : 5'b0); end
        end
        btn = 4'b0000;
        repeat (10) tick;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        for (int p = 0; p < 5; p++) begin
            btn = 4'b1000;
            for (int k = 1; k <= 10; k++) begin
                tick;
                if (v4) n++;
                total++; if (pulses !== ((k == 8) ? 5'b01000 : 5'b0)) begin bad++; $display("FAIL b2b p=%0d k=%0d pulses=%b", p, k, pulses); end
            end
            btn = 4'b0000;
            for (int k = 1; k <= 10; k++) begin
                tick;
                if (v4) n++;
            end
        end
        total++; if (n !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", n); end
    endtask

    task automatic test_reset_mid;
        btn = 4'b0010;
        repeat (4) tick;
        reset = 1'b0;
        #1;
        total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_assert pulses=%b busy=%b", pulses, busy); end
        repeat (6) begin
            tick;
            total++; if (pulses !== 5'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_hold pulses=%b busy=%b", pulses, busy); end
        end
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            total++; if (pulses !== ((k == 8) ? 5'b00010 : 5'b0)) begin bad++; $display("FAIL rst_mid k=%0d pulses=%b want=%b", k, pulses, (k == 8) ? 5'b00010 : 5'b0); end
        end
        btn = 4'b0000;
        repeat (10) tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle busy=%b want=0", busy); end
    endtask

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_multi;
        test_mode;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
